// File: rtl/qei_multi.sv
// Multi-channel quadrature encoder interface behind one Avalon-MM slave.
// Per channel: 2-flop sync, glitch filter, 4x decode, wrapping counter, status.
module qei_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2*NUM_CH-1:0] encab,
    input  logic [6:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata
);

    // Gray position: 00->0, 10->1, 11->2, 01->3 so forward steps are +1 mod 4
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    logic [31:0] cnt_arr [NUM_CH];
    logic [31:0] sts_arr [NUM_CH];
    logic [31:0] rd_val;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]       s1, s2, filt, prev;
        logic [7:0]       fcnt;
        logic             init, err, dir;
        logic [CNT_W-1:0] cnt;
        logic             hit, wr_cnt, wr_clr;
        logic             accept, step_fwd, step_rev, bad;
        logic [1:0]       delta;

        assign hit    = (address[6:1] == 6'(c));
        assign wr_cnt = write && hit && !address[0];
        assign wr_clr = write && hit && address[0] && writedata[0];

        // While init is set the counter runs regardless, so a stable 00 also clears it
        assign accept = (init || (s2 != filt)) && (fcnt == 8'(FILT_LEN - 1));

        assign delta    = gray_pos(filt) - gray_pos(prev);
        assign step_fwd = (delta == 2'd1);
        assign step_rev = (delta == 2'd3);
        assign bad      = (delta == 2'd2);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1   <= '0;
                s2   <= '0;
                filt <= '0;
                prev <= '0;
                fcnt <= '0;
                init <= 1'b1;
                err  <= 1'b0;
                dir  <= 1'b0;
                cnt  <= '0;
            end else begin
                s1 <= encab[2*c +: 2];
                s2 <= s1;
                if (accept) begin
                    filt <= s2;
                    fcnt <= '0;
                    init <= 1'b0;
                end else if (init || (s2 != filt)) begin
                    fcnt <= fcnt + 8'd1;
                end else begin
                    fcnt <= '0;
                end
                // First acceptance preloads prev too, so no step is decoded
                prev <= (accept && init) ? s2 : filt;
                if (wr_cnt) begin
                    cnt <= writedata[CNT_W-1:0];
                end else if (step_fwd) begin
                    cnt <= cnt + CNT_W'(1);
                    dir <= 1'b1;
                end else if (step_rev) begin
                    cnt <= cnt - CNT_W'(1);
                    dir <= 1'b0;
                end
                err <= bad || (err && !wr_clr);
            end
        end

        assign cnt_arr[c] = 32'(cnt);
        assign sts_arr[c] = {23'd0, init, 6'd0, dir, err};
    end

    // Unmatched channel indices fall through to zero
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (address[6:1] == 6'(c)) begin
                rd_val = address[0] ? sts_arr[c] : cnt_arr[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_qei_multi.sv
// Self-checking bench for qei_multi: vector table plus directed
// timing, error, bus-collision, wrap and reset sequences.
module tb_qei_multi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  encab = '0;
    logic [6:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;

    logic [1:0]  encab8 = '0;
    logic [6:0]  address8 = '0;
    logic        read8 = 1'b0;
    logic        write8 = 1'b0;
    logic [31:0] writedata8 = '0;
    logic [31:0] readdata8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qei_multi #(.NUM_CH(2), .CNT_W(32), .FILT_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .encab(encab),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata)
    );

    qei_multi #(.NUM_CH(1), .CNT_W(8), .FILT_LEN(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .encab(encab8),
        .address(address8), .read(read8), .write(write8),
        .writedata(writedata8), .readdata(readdata8)
    );

    typedef struct {
        int          ch;
        logic [1:0]  ab;
        logic [6:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(int ch, logic [1:0] ab,
                                logic [6:0] addr, logic [31:0] exp);
        vec_t v;
        v.ch = ch; v.ab = ab; v.addr = addr; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic hold(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(int ch, logic [1:0] ab);
        encab[2*ch +: 2] = ab;
    endtask

    task automatic bus_wr(bit s8, logic [6:0] a, logic [31:0] d);
        @(negedge clk);
        if (s8) begin
            address8 = a; writedata8 = d; write8 = 1'b1;
        end else begin
            address = a; writedata = d; write = 1'b1;
        end
        @(negedge clk);
        write = 1'b0;
        write8 = 1'b0;
    endtask

    task automatic bus_rd(bit s8, logic [6:0] a, output logic [31:0] v);
        @(negedge clk);
        if (s8) begin
            address8 = a; read8 = 1'b1;
        end else begin
            address = a; read = 1'b1;
        end
        @(negedge clk);
        read = 1'b0;
        read8 = 1'b0;
        v = s8 ? readdata8 : readdata;
    endtask

    logic [31:0] v;

    initial begin
        tbl[0]  = mk(0, 2'b00, 7'd0, 32'd0);
        tbl[1]  = mk(0, 2'b10, 7'd0, 32'd1);
        tbl[2]  = mk(0, 2'b11, 7'd0, 32'd2);
        tbl[3]  = mk(0, 2'b01, 7'd0, 32'd3);
        tbl[4]  = mk(0, 2'b00, 7'd0, 32'd4);
        tbl[5]  = mk(0, 2'b00, 7'd1, 32'h002);
        tbl[6]  = mk(1, 2'b00, 7'd2, 32'd0);
        tbl[7]  = mk(1, 2'b01, 7'd2, 32'hFFFF_FFFF);
        tbl[8]  = mk(1, 2'b11, 7'd2, 32'hFFFF_FFFE);
        tbl[9]  = mk(1, 2'b10, 7'd2, 32'hFFFF_FFFD);
        tbl[10] = mk(1, 2'b00, 7'd2, 32'hFFFF_FFFC);
        tbl[11] = mk(1, 2'b00, 7'd3, 32'h000);
        tbl[12] = mk(1, 2'b10, 7'd2, 32'hFFFF_FFFD);
        tbl[13] = mk(1, 2'b10, 7'd3, 32'h002);
        tbl[14] = mk(0, 2'b00, 7'd0, 32'd4);

        #1 check("rst_readdata", readdata, 32'd0);
        hold(3);
        reset_n = 1'b1;
        bus_rd(0, 7'd1, v);
        check("rst_init_flag", v, 32'h100);

        foreach (tbl[i]) begin
            set_ab(tbl[i].ch, tbl[i].ab);
            hold(10);
            bus_rd(0, tbl[i].addr, v);
            check($sformatf("vec%0d", i), v, tbl[i].exp);
        end

        // 3-cycle glitch on A must be rejected
        set_ab(0, 2'b10);
        hold(3);
        set_ab(0, 2'b00);
        hold(10);
        bus_rd(0, 7'd0, v);
        check("pulse3", v, 32'd4);

        // Held change: count updates on edge 7, visible in readdata from edge 8
        @(negedge clk);
        set_ab(0, 2'b10);
        address = 7'd0;
        read = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 7) check("lat_edge7", readdata, 32'd4);
            if (k == 8) check("lat_edge8", readdata, 32'd5);
        end
        read = 1'b0;
        hold(10);

        set_ab(0, 2'b00);
        hold(10);
        bus_rd(0, 7'd0, v);
        check("rev_back", v, 32'd4);

        set_ab(0, 2'b11);
        hold(10);
        bus_rd(0, 7'd1, v);
        check("err_set", v, 32'h001);
        bus_rd(0, 7'd0, v);
        check("err_cnt_hold", v, 32'd4);
        bus_wr(0, 7'd1, 32'd1);
        bus_rd(0, 7'd1, v);
        check("err_clear", v, 32'h000);

        set_ab(0, 2'b00);
        hold(10);
        bus_wr(0, 7'd1, 32'd1);
        bus_rd(0, 7'd1, v);
        check("err_clear2", v, 32'h000);

        // Clear lands on the same edge as a new illegal jump
        @(negedge clk);
        set_ab(0, 2'b11);
        hold(6);
        address = 7'd1; writedata = 32'd1; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        hold(8);
        bus_rd(0, 7'd1, v);
        check("clr_vs_set", v, 32'h001);

        // Count write lands on the same edge as a forward step
        @(negedge clk);
        set_ab(0, 2'b01);
        hold(6);
        address = 7'd0; writedata = 32'h1234; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        hold(10);
        bus_rd(0, 7'd0, v);
        check("wr_vs_step", v, 32'h1234);

        @(negedge clk);
        address = 7'd2; writedata = 32'h55; read = 1'b1; write = 1'b1;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check("rw_pre_value", readdata, 32'hFFFF_FFFD);
        bus_rd(0, 7'd2, v);
        check("rw_post_value", v, 32'h55);

        bus_wr(0, 7'd4, 32'h99);
        bus_rd(0, 7'd4, v);
        check("oor_read", v, 32'd0);
        bus_rd(0, 7'd0, v);
        check("oor_no_side", v, 32'h1234);

        bus_wr(1, 7'd0, 32'hFF);
        bus_rd(1, 7'd0, v);
        check("w8_load", v, 32'hFF);
        encab8 = 2'b10;
        hold(10);
        bus_rd(1, 7'd0, v);
        check("wrap8_up", v, 32'h00);
        encab8 = 2'b00;
        hold(10);
        bus_rd(1, 7'd0, v);
        check("wrap8_down", v, 32'hFF);

        // Asynchronous reset mid-motion with inputs at 11
        bus_rd(0, 7'd0, v);
        encab = 4'b1111;
        hold(3);
        reset_n = 1'b0;
        #1 check("rst_async", readdata, 32'd0);
        hold(2);
        reset_n = 1'b1;
        bus_rd(0, 7'd1, v);
        check("rst2_init", v, 32'h100);
        hold(12);
        bus_rd(0, 7'd0, v);
        check("rst2_cnt0", v, 32'd0);
        bus_rd(0, 7'd1, v);
        check("rst2_sts0", v, 32'h000);
        bus_rd(0, 7'd2, v);
        check("rst2_cnt1", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qei_multi.md
Name: qei_multi

Overview:
- Parametrised multi-channel quadrature encoder interface; successor to the single-channel QEI component instantiated per axis inside the qsystem.
- NUM_CH channels share one Avalon-MM slave. Per channel: input synchronisation, programmable glitch filter, 4x decode, wrapping position counter, direction bit, and a sticky illegal-transition error flag.
- Sits between the GPIO encoder pins and the Nios register space; replaces N separate QEI instances.

Parameters:
- NUM_CH, 2: number of encoder channels, 1..64.
- CNT_W, 32: position counter width, 2..32.
- FILT_LEN, 4: consecutive stable cycles required before a filtered input level is accepted, 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- encab  in  2*NUM_CH  encoder inputs; channel c uses A=encab[2c+1], B=encab[2c]
- address  in  7  word address: channel = address[6:1], register = address[0]
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  read data, registered

Behaviour:
- Reset (async assert, sync deassert expected upstream): all counts 0, error flags 0, direction 0, readdata 0, filter counters 0, sync flops 0, per-channel init flag set.
- Sync: 2 flops per input bit, no reset dependence beyond clearing to 0.
- Filter, per channel on the 2-bit {A,B}:
  - Sample differs from filtered state: counter increments.
  - Sample equals filtered state: counter clears.
  - Counter reaches FILT_LEN: filtered state <= sample, counter clears.
- Init flag:
  - First filter acceptance after reset loads the filtered state without counting, then clears the flag.
  - A stable sample equal to 00 also clears the flag after FILT_LEN cycles.
- Decode on each filtered-state change prev->new:
  - Forward sequence 00->10->11->01->00: count +1, dir=1.
  - Reverse sequence: count -1, dir=0.
  - Both bits changed: count unchanged, error flag set (sticky).
- Count arithmetic is modulo 2^CNT_W: 2^CNT_W-1 +1 -> 0; 0 -1 -> 2^CNT_W-1.
- Latency: a clean input change held stable is reflected in count on the (FILT_LEN+3)th rising edge after the first edge that samples it.
- Register 0 (COUNT):
  - Read returns count zero-extended to 32 bits.
  - Write loads writedata[CNT_W-1:0].
  - Write coincident with a decode step: write wins, step discarded.
- Register 1 (STATUS):
  - Read: bit0 = error, bit1 = dir, bit8 = init flag, others 0.
  - Write with writedata[0]=1 clears error.
  - Clear coincident with a new illegal transition: set wins.
- Read latency 1: readdata updates on the edge after read=1 and holds until the next read.
- Channel index >= NUM_CH: reads return 0, writes ignored.
- read and write asserted together: write performed, readdata returns the pre-write value.
- Channels are fully independent; simultaneous steps on all channels are all counted.

Test Plan:
- Reset, FILT_LEN=4; ch0 drives 00 then 10,11,01,00, each held 10 cycles -> COUNT0 = 4, STATUS0 = 0x002; COUNT1 = 0.
- Reverse sequence 00,01,11,10,00 on ch1 from count 0 -> COUNT1 = 0xFFFFFFFC, dir = 0; next forward step -> 0xFFFFFFFD.
- 3-cycle pulse on A with FILT_LEN=4 -> no count change. 4-cycle hold -> one step, observed exactly 7 edges after the input change.
- ch0 jumps 00->11 -> error=1, count unchanged. Write STATUS0=1 -> error=0. Clear in the same cycle as another 00->11 -> error stays 1.
- Write COUNT0=0x1234 in the same cycle as a forward step -> COUNT0 reads 0x1234. CNT_W=8 at count 0xFF +1 -> 0x00.
- Assert reset_n=0 mid-sequence with inputs at 11 -> counts and flags 0 immediately. After release, inputs held at 11 -> count stays 0, init flag clears.
